// File: rtl/whack_judge.sv
// rtl/whack_judge.sv - judges keypad presses against light-flick windows and keeps score
module whack_judge #(
  parameter int N_LIGHTS = 9,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    total_points,
  input  logic                deathmatch,
  input  logic [N_LIGHTS-1:0] lights,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [CNT_W-1:0]    hits,
  output logic [CNT_W-1:0]    misses,
  output logic [CNT_W-1:0]    flicks,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic                playing,
  output logic                game_over
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_WINDOW = 3'd2;
  localparam logic [2:0] S_JUDGED = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cur_idx_q, cur_idx_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] misses_q, misses_d;
  logic [CNT_W-1:0] flicks_q, flicks_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic             dm_q, dm_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             miss_pulse_q, miss_pulse_d;

  logic       lit;
  logic [3:0] lit_idx;
  logic       key_ok;
  logic       moved;
  logic       is_hit, is_miss, close;

  // Zero or multiple bits set are both treated as dark
  always_comb begin
    lit     = (lights != '0) && ((lights & (lights - N_LIGHTS'(1))) == '0);
    lit_idx = 4'd0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      if (lights[i]) lit_idx = 4'(i);
    end
    key_ok = key_valid && (32'(key_code) < N_LIGHTS);
    moved  = !lit || (lit_idx != cur_idx_q);
  end

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    flicks_d     = flicks_q;
    tot_d        = tot_q;
    dm_d         = dm_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    is_hit       = 1'b0;
    is_miss      = 1'b0;
    close        = 1'b0;

    case (state_q)
      S_ARMED: begin
        if (lit) begin
          state_d   = S_WINDOW;
          cur_idx_d = lit_idx;
        end
      end
      S_WINDOW: begin
        // A key is judged against the registered index even if the light moves this cycle
        if (key_ok) begin
          if (key_code == cur_idx_q) is_hit = 1'b1;
          else                       is_miss = 1'b1;
        end else if (moved) begin
          is_miss = 1'b1;
        end
        close = moved || (is_miss && dm_q);
        if (!close && (is_hit || is_miss)) state_d = S_JUDGED;
      end
      S_JUDGED: begin
        close = moved;
      end
      default: ;
    endcase

    if (is_hit) begin
      hits_d      = (hits_q == CNT_MAX) ? CNT_MAX : hits_q + 1'b1;
      hit_pulse_d = 1'b1;
    end
    if (is_miss) begin
      misses_d     = (misses_q == CNT_MAX) ? CNT_MAX : misses_q + 1'b1;
      miss_pulse_d = 1'b1;
    end

    if (close) begin
      flicks_d = (flicks_q == CNT_MAX) ? CNT_MAX : flicks_q + 1'b1;
      if ((({1'b0, flicks_q} + 1'b1) == {1'b0, tot_q}) || (is_miss && dm_q)) begin
        state_d = S_DONE;
      end else if (lit && (lit_idx != cur_idx_q)) begin
        state_d   = S_WINDOW;
        cur_idx_d = lit_idx;
      end else begin
        state_d = S_ARMED;
      end
    end

    if (start) begin
      state_d      = (total_points == '0) ? S_DONE : S_ARMED;
      cur_idx_d    = 4'd0;
      hits_d       = '0;
      misses_d     = '0;
      flicks_d     = '0;
      tot_d        = total_points;
      dm_d         = deathmatch;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_idx_q    <= 4'd0;
      hits_q       <= '0;
      misses_q     <= '0;
      flicks_q     <= '0;
      tot_q        <= '0;
      dm_q         <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      flicks_q     <= flicks_d;
      tot_q        <= tot_d;
      dm_q         <= dm_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign hits       = hits_q;
  assign misses     = misses_q;
  assign flicks     = flicks_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign playing    = (state_q == S_ARMED) || (state_q == S_WINDOW) || (state_q == S_JUDGED);
  assign game_over  = (state_q == S_DONE);

endmodule

// File: tb/tb_whack_judge.sv
// tb/tb_whack_judge.sv - scoreboard bench for whack_judge
module tb_whack_judge;

  localparam int N_LIGHTS = 9;
  localparam int CNT_W    = 6;

  logic                clk;
  logic                reset;
  logic                start;
  logic [CNT_W-1:0]    total_points;
  logic                deathmatch;
  logic [N_LIGHTS-1:0] lights;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [CNT_W-1:0]    hits, misses, flicks;
  logic                hit_pulse, miss_pulse, playing, game_over;

  int errors = 0;
  int checks = 0;

  // 1 = hit pulse expected, 2 = miss pulse expected
  int exp_q[$];

  whack_judge #(.N_LIGHTS(N_LIGHTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .total_points(total_points),
    .deathmatch(deathmatch), .lights(lights), .key_valid(key_valid),
    .key_code(key_code), .hits(hits), .misses(misses), .flicks(flicks),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .playing(playing),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && (hit_pulse || miss_pulse)) begin
      int got;
      int want;
      got = hit_pulse ? 1 : 2;
      checks++;
      if (hit_pulse && miss_pulse) begin
        errors++;
        $display("FAIL pulse_both: hit_pulse=1 miss_pulse=1 required at most one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got type %0d, required none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pulse_type: got %0d required %0d", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int tp, input logic dm);
    total_points = CNT_W'(tp);
    deathmatch   = dm;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic press(input int code);
    key_valid = 1'b1;
    key_code  = 4'(code);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; total_points = '0; deathmatch = 1'b0;
    lights = '0; key_valid = 1'b0; key_code = '0;
    #12;
    checks++;
    if ({hits, misses, flicks, hit_pulse, miss_pulse, playing, game_over} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got h=%0d m=%0d f=%0d hp=%b mp=%b pl=%b go=%b required all 0",
               hits, misses, flicks, hit_pulse, miss_pulse, playing, game_over);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    lights = 9'b000010000; tick();
    press(4);
    lights = 9'b000000100; tick();
    press(7);
    lights = '0; tick();
    checks++;
    if ({hits, misses, flicks, playing, game_over} !== '0) begin
      errors++;
      $display("FAIL idle_no_start: got h=%0d m=%0d f=%0d pl=%b go=%b required 0",
               hits, misses, flicks, playing, game_over);
    end
  endtask

  task automatic test_normal_game();
    do_start(3, 1'b0);
    checks++;
    if (playing !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_playing: got pl=%b go=%b required 1 0", playing, game_over);
    end
    lights = 9'b1 << 4; tick();
    exp_q.push_back(1);
    press(4);
    checks++;
    if (hits !== 6'd1 || hit_pulse !== 1'b1) begin
      errors++;
      $display("FAIL hit_latency: got hits=%0d hp=%b required 1 1", hits, hit_pulse);
    end
    lights = '0; tick();
    checks++;
    if (flicks !== 6'd1 || misses !== 6'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL first_close: got f=%0d m=%0d pl=%b required 1 0 1", flicks, misses, playing);
    end

    lights = 9'b1 << 2; tick();
    exp_q.push_back(2);
    press(7);
    press(2);
    checks++;
    if (misses !== 6'd1 || hits !== 6'd1) begin
      errors++;
      $display("FAIL wrong_key: got m=%0d h=%0d required 1 1", misses, hits);
    end
    lights = '0; tick();
    checks++;
    if (flicks !== 6'd2) begin
      errors++;
      $display("FAIL second_close: got f=%0d required 2", flicks);
    end

    lights = 9'b1; tick();
    exp_q.push_back(2);
    lights = '0; tick();
    checks++;
    if (misses !== 6'd2 || flicks !== 6'd3 || game_over !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: got m=%0d f=%0d go=%b pl=%b required 2 3 1 0",
               misses, flicks, game_over, playing);
    end
    lights = 9'b1 << 3; tick();
    press(3);
    lights = '0; tick();
    checks++;
    if (hits !== 6'd1 || misses !== 6'd2 || flicks !== 6'd3 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: got h=%0d m=%0d f=%0d go=%b required 1 2 3 1",
               hits, misses, flicks, game_over);
    end
  endtask

  task automatic test_deathmatch();
    do_start(25, 1'b1);
    lights = 9'b1 << 5; tick();
    exp_q.push_back(2);
    lights = '0; tick();
    checks++;
    if (misses !== 6'd1 || flicks !== 6'd1 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL deathmatch_miss: got m=%0d f=%0d go=%b required 1 1 1", misses, flicks, game_over);
    end
    do_start(25, 1'b0);
    checks++;
    if ({hits, misses, flicks} !== '0 || playing !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got h=%0d m=%0d f=%0d pl=%b go=%b required 0 0 0 1 0",
               hits, misses, flicks, playing, game_over);
    end
  endtask

  task automatic test_simultaneous();
    lights = 9'b1 << 3; tick();
    exp_q.push_back(1);
    lights = '0;
    press(3);
    checks++;
    if (hits !== 6'd1 || misses !== 6'd0 || flicks !== 6'd1) begin
      errors++;
      $display("FAIL key_at_dark: got h=%0d m=%0d f=%0d required 1 0 1", hits, misses, flicks);
    end
    lights = 9'b000000011; tick();
    press(0);
    lights = '0; tick();
    checks++;
    if (hits !== 6'd1 || misses !== 6'd0 || flicks !== 6'd1 || playing !== 1'b1) begin
      errors++;
      $display("FAIL multi_bit_dark: got h=%0d m=%0d f=%0d pl=%b required 1 0 1 1",
               hits, misses, flicks, playing);
    end
  endtask

  task automatic test_back_to_back();
    lights = 9'b1 << 1; tick();
    exp_q.push_back(2);
    lights = 9'b1 << 6; tick();
    checks++;
    if (misses !== 6'd1 || flicks !== 6'd2) begin
      errors++;
      $display("FAIL index_change: got m=%0d f=%0d required 1 2", misses, flicks);
    end
    exp_q.push_back(1);
    press(6);
    lights = 9'b1 << 8; tick();
    press(12);
    exp_q.push_back(2);
    lights = '0; tick();
    tick();
    checks++;
    if (hits !== 6'd2 || misses !== 6'd2 || flicks !== 6'd4) begin
      errors++;
      $display("FAIL back_to_back: got h=%0d m=%0d f=%0d required 2 2 4", hits, misses, flicks);
    end
  endtask

  task automatic test_zero_total_and_async_reset();
    do_start(0, 1'b0);
    checks++;
    if (game_over !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL zero_total: got go=%b pl=%b required 1 0", game_over, playing);
    end
    do_start(5, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (playing !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pl=%b go=%b required 0 0", playing, game_over);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal_game();
    test_deathmatch();
    test_simultaneous();
    test_back_to_back();
    test_zero_total_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
